// File: rtl/cripto_pkg.sv
// -----------------------------------------------------------------------------
// cripto_pkg
// Shared constants and types for the cripto_feeder byte-to-block front end.
//   BLOCK_W          width of one cipher block
//   BYTES_PER_BLOCK  bytes packed into one block
//   QUEUE_DEPTH      blocks held between packer and cipher core
//   issue_state_t    issue FSM states
//   block_t          queued entry: mode bit above the 64-bit block
// -----------------------------------------------------------------------------
package cripto_pkg;

    localparam int unsigned BLOCK_W         = 64;
    localparam int unsigned BYTES_PER_BLOCK = 8;
    localparam int unsigned QUEUE_DEPTH     = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic               mode;
        logic [BLOCK_W-1:0] data;
    } block_t;

endpackage

// File: rtl/cripto_block_fifo.sv
// -----------------------------------------------------------------------------
// cripto_block_fifo
// Two-entry FIFO of {mode, block} words between the byte packer and the
// issue FSM. A push and a pop in the same cycle both take effect, also when
// the FIFO is full (the pushed word lands in the slot being vacated).
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   push       write push_data (ignored when full without a same-cycle pop)
//   push_data  {mode, block} to enqueue
//   pop        drop the head entry (ignored when empty)
//   head       current head entry
//   count      number of stored entries (0..2)
// -----------------------------------------------------------------------------
module cripto_block_fifo
    import cripto_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [BLOCK_W:0] push_data,
    input  logic             pop,
    output logic [BLOCK_W:0] head,
    output logic [1:0]       count
);

    localparam logic [1:0] FullCnt = 2'(QUEUE_DEPTH);

    logic [BLOCK_W:0] mem_q [QUEUE_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != FullCnt) || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cripto_feeder.sv
// -----------------------------------------------------------------------------
// cripto_feeder
// Packs a byte stream MSB-first into 64-bit blocks, queues up to two full
// blocks and hands them one at a time to a cipher core.
// Optional feature: define CRIPTO_FEEDER_PAD_EN to let last_i close a partial
// block with zero padding; without it last_i is ignored.
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   byte_i        stream byte; byte_valid_i/byte_ready_o handshake
//   last_i        final byte of message (padding build only)
//   mode_i        1=encrypt 0=decrypt, latched with first byte of a block
//   start_o       one-cycle start pulse to the core
//   enc_dec_o     mode of the issued block
//   data_o        issued block, held until the core reports ready
//   busy_i        core busy; blocks issue only while low
//   ready_i       core result ready; pops the issued block
//   pending_o     full blocks waiting in the queue (0..2)
// -----------------------------------------------------------------------------
module cripto_feeder
    import cripto_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    input  logic               last_i,
    input  logic               mode_i,
    output logic               start_o,
    output logic               enc_dec_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               busy_i,
    input  logic               ready_i,
    output logic [1:0]         pending_o
);

    localparam logic [2:0] LastIdx = 3'(BYTES_PER_BLOCK - 1);
    localparam logic [1:0] FullCnt = 2'(QUEUE_DEPTH);

    // Pack register
    logic [BLOCK_W-1:0] pack_data_q, pack_data_d;
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic               pack_mode_q, pack_mode_d;
    logic               pack_full_q, pack_full_d;

    logic               accept;
    logic               close_block;
    logic               push;
    logic               pop;
    logic [1:0]         fifo_count;
    logic [BLOCK_W:0]   fifo_head;
    block_t             next_blk;
    logic               head_avail;

    // Issue FSM and registered outputs
    issue_state_t       state_q;
    logic               start_q;
    logic               enc_dec_q;
    logic [BLOCK_W-1:0] data_q;

    // Gating with reset keeps ready low while in reset and high right after.
    assign byte_ready_o = reset && !pack_full_q;
    assign accept       = byte_valid_i && byte_ready_o;

`ifdef CRIPTO_FEEDER_PAD_EN
    // Low bytes of the pack register are already zero, so closing early pads.
    assign close_block = accept && ((byte_cnt_q == LastIdx) || last_i);
`else
    logic unused_last;
    assign unused_last = last_i;
    assign close_block = accept && (byte_cnt_q == LastIdx);
`endif

    assign pop  = (state_q == StWait) && ready_i;
    assign push = pack_full_q && ((fifo_count != FullCnt) || pop);

    always_comb begin
        pack_data_d = pack_data_q;
        byte_cnt_d  = byte_cnt_q;
        pack_mode_d = pack_mode_q;
        pack_full_d = pack_full_q;
        if (push) begin
            pack_data_d = '0;
            byte_cnt_d  = 3'd0;
            pack_mode_d = 1'b0;
            pack_full_d = 1'b0;
        end else if (accept) begin
            for (int unsigned i = 0; i < BYTES_PER_BLOCK; i++) begin
                if (byte_cnt_q == 3'(i)) begin
                    pack_data_d[BLOCK_W-1-8*i -: 8] = byte_i;
                end
            end
            if (byte_cnt_q == 3'd0) begin
                pack_mode_d = mode_i;
            end
            if (close_block) begin
                pack_full_d = 1'b1;
                byte_cnt_d  = 3'd0;
            end else begin
                byte_cnt_d  = byte_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pack_data_q <= '0;
            byte_cnt_q  <= 3'd0;
            pack_mode_q <= 1'b0;
            pack_full_q <= 1'b0;
        end else begin
            pack_data_q <= pack_data_d;
            byte_cnt_q  <= byte_cnt_d;
            pack_mode_q <= pack_mode_d;
            pack_full_q <= pack_full_d;
        end
    end

    cripto_block_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({pack_mode_q, pack_data_q}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // An empty queue being pushed this cycle forwards the pack register, so
    // the block can issue without waiting a cycle for the queue write.
    assign head_avail = (fifo_count != 2'd0) || push;
    assign next_blk   = (fifo_count == 2'd0) ? block_t'({pack_mode_q, pack_data_q})
                                             : block_t'(fifo_head);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            enc_dec_q <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (head_avail && !busy_i) begin
                        state_q   <= StIssue;
                        start_q   <= 1'b1;
                        data_q    <= next_blk.data;
                        enc_dec_q <= next_blk.mode;
                    end
                end
                StIssue: begin
                    start_q <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign start_o   = start_q;
    assign enc_dec_o = enc_dec_q;
    assign data_o    = data_q;
    assign pending_o = fifo_count;

endmodule

// File: tb/tb_cripto_feeder.sv
// -----------------------------------------------------------------------------
// tb_cripto_feeder
// Directed bench for cripto_feeder. Expected blocks are queued when their
// bytes are driven and compared when start_o reports an issue.
// -----------------------------------------------------------------------------
module tb_cripto_feeder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        last_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        start_o;
    logic        enc_dec_o;
    logic [63:0] data_o;
    logic        busy_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [1:0]  pending_o;

    int          tests = 0;
    int          fails = 0;
    logic [64:0] sb[$];

    always #5 clock = ~clock;

    cripto_feeder dut (
        .clock        (clock),
        .reset        (reset),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .last_i       (last_i),
        .mode_i       (mode_i),
        .start_o      (start_o),
        .enc_dec_o    (enc_dec_o),
        .data_o       (data_o),
        .busy_i       (busy_i),
        .ready_i      (ready_i),
        .pending_o    (pending_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic m, input logic l);
        logic acc;
        byte_i       = b;
        mode_i       = m;
        last_i       = l;
        byte_valid_i = 1'b1;
        acc          = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = byte_ready_o;
            @(posedge clock);
            #1;
        end
        chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_block(input logic [63:0] blk, input int n, input logic mf,
                              input logic mr, input logic lastf);
        for (int i = 0; i < n; i++) begin
            send_byte(blk[63-8*i -: 8], (i == 0) ? mf : mr, lastf && (i == n - 1));
        end
        byte_valid_i = 1'b0;
        last_i       = 1'b0;
    endtask

    task automatic check_head(input string tag);
        logic [64:0] exp;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk({tag, "_data"}, data_o, exp[63:0]);
            chk({tag, "_mode"}, 64'(enc_dec_o), 64'(exp[64]));
        end
    endtask

    // Returns in the cycle where start_o is high.
    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (start_o) seen = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        chk({tag, "_start_seen"}, 64'(seen), 64'd1);
        if (seen) check_head(tag);
    endtask

    // From the issue cycle: move into WAIT, pulse ready_i for one cycle.
    task automatic pulse_ready();
        @(posedge clock);
        #1;
        ready_i = 1'b1;
        @(posedge clock);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, 64'(start_o), 64'd0);
        chk({tag, "_enc"}, 64'(enc_dec_o), 64'd0);
        chk({tag, "_data"}, data_o, 64'd0);
        chk({tag, "_pending"}, 64'(pending_o), 64'd0);
        chk({tag, "_bready"}, 64'(byte_ready_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [63:0] blks [3];
        logic        mds  [3];

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("rst");
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_release_bready", 64'(byte_ready_o), 64'd1);
        @(posedge clock);
        #1;

        // Basic block, exact latency, hold until ready
        sb.push_back({1'b1, 64'hA5A5A5A501234567});
        send_block(64'hA5A5A5A501234567, 8, 1'b1, 1'b1, 1'b0);
        chk("lat_c1_start", 64'(start_o), 64'd0);
        @(posedge clock);
        #1;
        chk("lat_c2_start", 64'(start_o), 64'd1);
        check_head("blk1");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("hold_start", 64'(start_o), 64'd0);
            chk("hold_data", data_o, 64'hA5A5A5A501234567);
            chk("hold_pending", 64'(pending_o), 64'd1);
        end
        ready_i = 1'b1;
        @(posedge clock);
        #1;
        ready_i = 1'b0;
        chk("blk1_popped", 64'(pending_o), 64'd0);

        // Mode latched on first byte only
        sb.push_back({1'b0, 64'h272612A5EE5D03AD});
        send_block(64'h272612A5EE5D03AD, 8, 1'b0, 1'b1, 1'b0);
        wait_start("blk2");
        pulse_ready();

        // ready_i while idle with empty queue
        ready_i = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        ready_i = 1'b0;
        chk("idle_ready_pending", 64'(pending_o), 64'd0);
        chk("idle_ready_start", 64'(start_o), 64'd0);

        // Back-to-back 24 bytes with busy core, then drain in order
        blks[0] = 64'h0102030405060708; mds[0] = 1'b1;
        blks[1] = 64'h1112131415161718; mds[1] = 1'b0;
        blks[2] = 64'hF1E2D3C4B5A69788; mds[2] = 1'b1;
        busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back({mds[i], blks[i]});
            send_block(blks[i], 8, mds[i], ~mds[i], 1'b0);
        end
        @(posedge clock);
        #1;
        chk("b2b_pending", 64'(pending_o), 64'd2);
        chk("b2b_bready", 64'(byte_ready_o), 64'd0);
        chk("b2b_no_start", 64'(start_o), 64'd0);
        busy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_start("b2b");
            pulse_ready();
            if (i == 0) chk("b2b_push_pop_full", 64'(pending_o), 64'd2);
        end
        chk("b2b_drained", 64'(pending_o), 64'd0);
        chk("b2b_bready_end", 64'(byte_ready_o), 64'd1);

        // last_i handling
`ifdef CRIPTO_FEEDER_PAD_EN
        sb.push_back({1'b1, 64'h2726120000000000});
        send_block(64'h2726120000000000, 3, 1'b1, 1'b1, 1'b1);
        wait_start("pad");
        pulse_ready();
`else
        send_block(64'h2726120000000000, 3, 1'b1, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (start_o) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        chk("nopad_no_start", 64'(seen), 64'd0);
        chk("nopad_pending", 64'(pending_o), 64'd0);
`endif

        // Reset mid-block
        send_block(64'hDEADBEEFCAFE0000, 5, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_mid_bready", 64'(byte_ready_o), 64'd1);
        @(posedge clock);
        #1;

        // Reset during WAIT
        sb.push_back({1'b1, 64'h0F0E0D0C0B0A0908});
        send_block(64'h0F0E0D0C0B0A0908, 8, 1'b1, 1'b1, 1'b0);
        wait_start("pre_rst");
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_wait");
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Fresh block after reset: no stale bytes
        sb.push_back({1'b0, 64'h8877665544332211});
        send_block(64'h8877665544332211, 8, 1'b0, 1'b0, 1'b0);
        wait_start("fresh");
        pulse_ready();
        chk("fresh_pending", 64'(pending_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
